// File: rtl/bdd_node_insert.sv
// Unique-table insert engine: reduces low==high requests, scans the node SRAM
// for a duplicate via port B, and appends new nodes via port A.
module bdd_node_insert #(
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int VAR_WIDTH  = 4,
  parameter int PTR_WIDTH  = 15,
  parameter int NODE_BASE  = 2,
  localparam int DATA_WIDTH = VAR_WIDTH + 2*PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VAR_WIDTH-1:0]  in_var,
  input  logic [PTR_WIDTH-1:0]  in_low,
  input  logic [PTR_WIDTH-1:0]  in_high,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PTR_WIDTH-1:0]  out_ptr,
  output logic                  out_hit,
  output logic                  out_full,
  output logic [ADDR_WIDTH:0]   node_count,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] q_b
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN_RD, S_SCAN_CMP, S_WRITE, S_RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);
  localparam logic [ADDR_WIDTH:0]   FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_node;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_node_count;
  logic                  r_out_valid, r_out_hit, r_out_full, r_we_a;
  logic [PTR_WIDTH-1:0]  r_out_ptr;
  logic [ADDR_WIDTH-1:0] r_addr_a, r_addr_b;
  logic [DATA_WIDTH-1:0] r_data_a;

  logic [DATA_WIDTH-1:0] w_in_node;
  logic [ADDR_WIDTH:0]   w_idx_next;
  logic [PTR_WIDTH-1:0]  w_idx_ptr;

  assign w_in_node  = {in_var, in_low, in_high};
  assign w_idx_next = {1'b0, r_idx} + 1'b1;
  assign w_idx_ptr  = PTR_WIDTH'(r_idx) + PTR_WIDTH'(NODE_BASE);

  // clear takes the IDLE cycle, so no request may be accepted alongside it
  assign in_ready   = (r_state == S_IDLE) && !clear;
  assign out_valid  = r_out_valid;
  assign out_ptr    = r_out_ptr;
  assign out_hit    = r_out_hit;
  assign out_full   = r_out_full;
  assign node_count = r_node_count;
  assign addr_a     = r_addr_a;
  assign data_a     = r_data_a;
  assign we_a       = r_we_a;
  assign addr_b     = r_addr_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_node       <= '0;
      r_idx        <= '0;
      r_node_count <= '0;
      r_out_valid  <= 1'b0;
      r_out_hit    <= 1'b0;
      r_out_full   <= 1'b0;
      r_out_ptr    <= '0;
      r_we_a       <= 1'b0;
      r_data_a     <= '0;
      r_addr_a     <= LAST;
      r_addr_b     <= LAST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_node_count <= '0;
            r_addr_a     <= LAST;
          end else if (in_valid) begin
            r_node <= w_in_node;
            if (in_low == in_high) begin
              r_out_valid <= 1'b1;
              r_out_ptr   <= in_low;
              r_out_hit   <= 1'b1;
              r_out_full  <= 1'b0;
              r_state     <= S_RESP;
            end else if (r_node_count == '0) begin
              r_we_a   <= 1'b1;
              r_addr_a <= r_node_count[ADDR_WIDTH-1:0];
              r_data_a <= w_in_node;
              r_state  <= S_WRITE;
            end else begin
              r_idx    <= '0;
              r_addr_b <= '0;
              r_state  <= S_SCAN_RD;
            end
          end
        end
        S_SCAN_RD: r_state <= S_SCAN_CMP;
        S_SCAN_CMP: begin
          if (q_b == r_node) begin
            r_out_valid <= 1'b1;
            r_out_ptr   <= w_idx_ptr;
            r_out_hit   <= 1'b1;
            r_out_full  <= 1'b0;
            r_addr_b    <= LAST;
            r_state     <= S_RESP;
          end else if (w_idx_next < r_node_count) begin
            r_idx    <= w_idx_next[ADDR_WIDTH-1:0];
            r_addr_b <= w_idx_next[ADDR_WIDTH-1:0];
            r_state  <= S_SCAN_RD;
          end else if (r_node_count == FULL) begin
            r_out_valid <= 1'b1;
            r_out_ptr   <= '0;
            r_out_hit   <= 1'b0;
            r_out_full  <= 1'b1;
            r_addr_b    <= LAST;
            r_state     <= S_RESP;
          end else begin
            r_we_a   <= 1'b1;
            r_addr_a <= r_node_count[ADDR_WIDTH-1:0];
            r_data_a <= r_node;
            r_addr_b <= LAST;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_we_a <= 1'b0;
          if (r_node_count != FULL) r_node_count <= r_node_count + 1'b1;
          r_out_valid <= 1'b1;
          r_out_ptr   <= PTR_WIDTH'(r_addr_a) + PTR_WIDTH'(NODE_BASE);
          r_out_hit   <= 1'b0;
          r_out_full  <= 1'b0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_node_insert.sv
// Directed bench for bdd_node_insert with a behavioural node SRAM and a
// response scoreboard queue.
module tb_bdd_node_insert;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready;
  logic [3:0]  in_var;
  logic [14:0] in_low, in_high;
  logic        out_valid, out_ready, out_hit, out_full;
  logic [14:0] out_ptr;
  logic [3:0]  node_count;
  logic [2:0]  addr_a, addr_b;
  logic [33:0] data_a, q_b;
  logic        we_a;

  typedef struct {
    logic [14:0] ptr;
    logic        hit;
    logic        full;
  } exp_t;
  exp_t sbq[$];

  int ncmp = 0, nerr = 0;
  int we_cnt = 0;
  logic [2:0]  wr_addr;
  logic [33:0] wr_data;
  logic [33:0] mem [8];

  bdd_node_insert dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_var(in_var), .in_low(in_low), .in_high(in_high),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ptr(out_ptr), .out_hit(out_hit), .out_full(out_full),
    .node_count(node_count),
    .addr_a(addr_a), .data_a(data_a), .we_a(we_a),
    .addr_b(addr_b), .q_b(q_b)
  );

  always #5 clk = ~clk;

  // synchronous-read node SRAM
  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    q_b <= mem[addr_b];
  end

  always @(negedge clk) begin
    if (we_a) begin
      we_cnt  = we_cnt + 1;
      wr_addr = addr_a;
      wr_data = data_a;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [3:0] v, input logic [14:0] l, input logic [14:0] h,
                      input logic [14:0] eptr, input logic ehit, input logic efull);
    int n;
    exp_t e;
    e.ptr = eptr; e.hit = ehit; e.full = efull;
    sbq.push_back(e);
    in_var = v; in_low = l; in_high = h; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat = negedges waited after the post-accept negedge until out_valid
  task automatic get_resp(input string tag, input int exp_lat);
    int lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_sbq"}, 64'(sbq.size() != 0), 64'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_ptr"},  64'(out_ptr),  64'(e.ptr));
      chk({tag, "_hit"},  64'(out_hit),  64'(e.hit));
      chk({tag, "_full"}, 64'(out_full), 64'(e.full));
    end
    @(negedge clk);
    chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int wc0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_var = '0; in_low = '0; in_high = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(node_count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hit_full", 64'({out_hit, out_full}), 64'd0);
    chk("rst_ptr", 64'(out_ptr), 64'd0);
    chk("rst_we_data", 64'({we_a, data_a}), 64'd0);
    chk("rst_addr_a", 64'(addr_a), 64'd7);
    chk("rst_addr_b", 64'(addr_b), 64'd7);
    rst = 1'b0;
    @(negedge clk);

    // 1: first node goes straight to WRITE at entry 0
    wc0 = we_cnt;
    send(4'd3, 15'd0, 15'd1, 15'd2, 1'b0, 1'b0);
    get_resp("t1", 1);
    chk("t1_we_pulses", 64'(we_cnt - wc0), 64'd1);
    chk("t1_wr_addr", 64'(wr_addr), 64'd0);
    chk("t1_wr_data", 64'(wr_data), 64'({4'd3, 15'd0, 15'd1}));
    chk("t1_count", 64'(node_count), 64'd1);

    // 2: duplicate found at idx 0
    wc0 = we_cnt;
    send(4'd3, 15'd0, 15'd1, 15'd2, 1'b1, 1'b0);
    get_resp("t2", 2);
    chk("t2_no_write", 64'(we_cnt - wc0), 64'd0);
    chk("t2_count", 64'(node_count), 64'd1);

    // 3: reduction rule, no SRAM address movement
    send(4'd5, 15'd7, 15'd7, 15'd7, 1'b1, 1'b0);
    get_resp("t3", 0);
    chk("t3_addr_a", 64'(addr_a), 64'd0);
    chk("t3_addr_b", 64'(addr_b), 64'd7);

    // 4: fill to DEPTH; each miss scans 2*count cycles then writes
    for (int i = 1; i < 8; i++) begin
      send(4'(i), 15'(i), 15'(i + 20), 15'(i + 2), 1'b0, 1'b0);
      get_resp($sformatf("t4_fill%0d", i), 2*i + 1);
    end
    chk("t4_count_full", 64'(node_count), 64'd8);
    send(4'd7, 15'd7, 15'd27, 15'd9, 1'b1, 1'b0);
    get_resp("t4_hit_last", 16);
    wc0 = we_cnt;
    send(4'd9, 15'd1, 15'd2, 15'd0, 1'b0, 1'b1);
    get_resp("t4_full", 16);
    chk("t4_full_no_write", 64'(we_cnt - wc0), 64'd0);
    chk("t4_count_sat", 64'(node_count), 64'd8);

    // 5: back-pressure holds the result, then clear empties the table
    out_ready = 1'b0;
    send(4'd1, 15'd5, 15'd5, 15'd5, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_ptr", 64'({out_ptr, out_hit, out_full}), 64'({15'd5, 1'b1, 1'b0}));
      chk("t5_hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    get_resp("t5", 0);
    clear = 1'b1;
    #1;
    chk("t5_clear_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    chk("t5_clear_count", 64'(node_count), 64'd0);
    chk("t5_clear_addr_a", 64'(addr_a), 64'd7);
    send(4'd6, 15'd3, 15'd4, 15'd2, 1'b0, 1'b0);
    get_resp("t5_after_clear", 1);
    chk("t5_wr_addr", 64'(wr_addr), 64'd0);

    // 6: reset lands while the single entry is being compared
    send(4'd8, 15'd1, 15'd3, 15'd3, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_count", 64'(node_count), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_out", 64'({out_valid, out_hit, out_full, out_ptr}), 64'd0);
    chk("t6_we_data", 64'({we_a, data_a}), 64'd0);
    chk("t6_addrs", 64'({addr_a, addr_b}), 64'({3'd7, 3'd7}));
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(4'd8, 15'd1, 15'd3, 15'd2, 1'b0, 1'b0);
    get_resp("t6_after_rst", 1);
    chk("t6_wr_addr", 64'(wr_addr), 64'd0);
    chk("t6_count_after", 64'(node_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
